// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus plus the sync_fifo write port shared through the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_wr_enable;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full;

  // Arbiter side
  modport slave (
    input  req, req_data, fifo_full,
    output gnt, fifo_wr_enable, fifo_data_in
  );

  // Producers / FIFO side
  modport master (
    output req, req_data, fifo_full,
    input  gnt, fifo_wr_enable, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational circular priority select: first set req bit at or after rr_ptr.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W-1:0] pos;

  // Scan from the farthest offset back to rr_ptr so the nearest hit is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      pos = PTR_W'((32'(rr_ptr) + k - 1) % NUM_REQ);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Optional macro FIFO_ARB_STATS_EN adds per-producer saturating accepted-beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] grant_count
`endif
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   beat_cnt;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] gnt_c;
  logic [NUM_REQ-1:0] accept;
  logic [WIDTH-1:0]   data_c;
  logic               xfer;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == NUM_REQ - 1) ? '0 : p + PTR_W'(1);
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Grant is gated by reset as well so outputs drop the instant reset rises.
  always_comb begin
    gnt_c = '0;
    if (!reset && !bus.fifo_full) begin
      if (state == IDLE) begin
        if (pick_valid) gnt_c[pick_idx] = 1'b1;
      end else begin
        gnt_c[owner] = bus.req[owner];
      end
    end
  end

  always_comb begin
    data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) data_c = data_c | bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign accept             = gnt_c & bus.req;
  assign xfer               = |accept;
  assign bus.gnt            = gnt_c;
  assign bus.fifo_wr_enable = xfer;
  assign bus.fifo_data_in   = data_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            owner    <= pick_idx;
            beat_cnt <= CNT_W'(1);
            if (MAX_BURST == 1) rr_ptr <= ptr_inc(pick_idx);
            else                state  <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (32'(beat_cnt) + 32'd1 == MAX_BURST) begin
              rr_ptr <= ptr_inc(owner);
              state  <= IDLE;
            end
          end else if (!bus.req[owner]) begin
            rr_ptr <= ptr_inc(owner);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] stat_q [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i] && stat_q[i] != '1) stat_q[i] <= stat_q[i] + STATS_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    assign grant_count[g*STATS_W +: STATS_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a 16-deep FIFO model on the write port.
module tb_fifo_wr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.WIDTH(8), .NUM_REQ(4)) bus();

`ifdef FIFO_ARB_STATS_EN
  logic [4*16-1:0] grant_count;
`endif

  fifo_wr_arbiter #(
    .WIDTH     (8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       we;
    logic [7:0] data;
  } vec_t;

  vec_t       vecs [15];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] fq [$];
  bit         model_en = 1'b0;
  bit         rd = 1'b0;
  logic [3:0] s_gnt;
  logic       s_we;
  logic [7:0] s_data;
  logic [7:0] popped = '0;
  int         acc [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    #1;
    s_gnt  = bus.gnt;
    s_we   = bus.fifo_wr_enable;
    s_data = bus.fifo_data_in;
    @(posedge clk);
    #1;
    if (model_en) begin
      if (rd && fq.size() > 0) popped = fq.pop_front();
      if (s_we) begin
        chk("no_overflow", 32'(fq.size() < 16), 32'd1);
        if (fq.size() < 16) fq.push_back(s_data);
      end
      bus.fifo_full = (fq.size() == 16);
    end
    for (int i = 0; i < 4; i++) if (s_gnt[i] && bus.req[i]) acc[i]++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.fifo_full = 1'b0;
    fq.delete();
    rd = 1'b0;
    for (int i = 0; i < 4; i++) acc[i] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    int cyc;
    logic [3:0] exp_g;

    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[1]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC2};
    vecs[3]  = '{4'b0110, 1'b0, 4'b0100, 1'b1, 8'hC2};
    vecs[4]  = '{4'b0110, 1'b1, 4'b0000, 1'b0, 8'h00};
    vecs[5]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[6]  = '{4'b0011, 1'b0, 4'b0001, 1'b1, 8'hA0};
    vecs[7]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 8'hA0};
    vecs[8]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 8'hA0};
    vecs[9]  = '{4'b1011, 1'b0, 4'b0001, 1'b1, 8'hA0};
    vecs[10] = '{4'b1011, 1'b0, 4'b0010, 1'b1, 8'hB1};
    vecs[11] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[12] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 8'hD3};
    vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00};
    vecs[14] = '{4'b1000, 1'b0, 4'b1000, 1'b1, 8'hD3};

    // Outputs held at zero while reset is high, even with every producer requesting.
    bus.req = 4'b1111;
    bus.req_data = 32'hD3C2B1A0;
    bus.fifo_full = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_gnt",  32'(bus.gnt), 32'h0);
    chk("rst_we",   32'(bus.fifo_wr_enable), 32'h0);
    chk("rst_data", 32'(bus.fifo_data_in), 32'h0);
    @(negedge clk);

    // Directed vector table, fifo_full driven directly.
    do_reset();
    model_en = 1'b0;
    bus.req_data = 32'hD3C2B1A0;
    for (int v = 0; v < 15; v++) begin
      bus.req = vecs[v].req;
      bus.fifo_full = vecs[v].full;
      tick();
      chk($sformatf("vec%0d_gnt", v),  32'(s_gnt),  32'(vecs[v].gnt));
      chk($sformatf("vec%0d_we", v),   32'(s_we),   32'(vecs[v].we));
      chk($sformatf("vec%0d_data", v), 32'(s_data), 32'(vecs[v].data));
    end

    // Single producer: ten beats in order, ownership renewed every four.
    do_reset();
    model_en = 1'b1;
    bus.req = 4'b0001;
    k = 0;
    cyc = 0;
    while (k < 10 && cyc < 40) begin
      bus.req_data[7:0] = 8'(8'hA0 + k);
      tick();
      cyc++;
      if (s_gnt[0]) k++;
    end
    bus.req = '0;
    chk("sp_beats", 32'(k), 32'd10);
    chk("sp_cycles", 32'(cyc), 32'd10);
    chk("sp_fifo_size", 32'(fq.size()), 32'd10);
    for (int i = 0; i < 10 && i < fq.size(); i++)
      chk($sformatf("sp_fifo%0d", i), 32'(fq[i]), 32'(8'hA0 + i));

    // Contention: all four request, FIFO drained every cycle.
    do_reset();
    model_en = 1'b1;
    rd = 1'b1;
    bus.req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(i*16 + acc[i]);
      tick();
      exp_g = 4'b0001 << ((c / 4) % 4);
      chk($sformatf("cont_gnt%0d", c), 32'(s_gnt), 32'(exp_g));
    end
    bus.req = '0;
    chk("cont_acc0", 32'(acc[0]), 32'd8);
    chk("cont_acc1", 32'(acc[1]), 32'd4);
    chk("cont_acc2", 32'(acc[2]), 32'd4);
    chk("cont_acc3", 32'(acc[3]), 32'd4);
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < 4; i++)
      chk($sformatf("stats%0d", i), 32'(grant_count[i*16 +: 16]), 32'(acc[i]));
`endif

    // Full: fill from producer 1, hold while full, one read frees one slot.
    do_reset();
    model_en = 1'b1;
    rd = 1'b0;
    bus.req = 4'b0010;
    k = 0;
    cyc = 0;
    while (fq.size() < 16 && cyc < 40) begin
      bus.req_data[15:8] = 8'(8'h10 + k);
      tick();
      cyc++;
      if (s_gnt[1]) k++;
    end
    chk("full_beats", 32'(k), 32'd16);
    bus.req_data[15:8] = 8'h20;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("full_gnt%0d", c), 32'(s_gnt), 32'h0);
      chk($sformatf("full_we%0d", c),  32'(s_we),  32'h0);
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    chk("full_read_gnt", 32'(s_gnt), 32'h0);
    chk("full_popped", 32'(popped), 32'h10);
    tick();
    chk("full_resume_gnt",  32'(s_gnt),  32'b0010);
    chk("full_resume_data", 32'(s_data), 32'h20);
    chk("full_size", 32'(fq.size()), 32'd16);
    if (fq.size() == 16) begin
      chk("full_head", 32'(fq[0]),  32'h11);
      chk("full_tail", 32'(fq[15]), 32'h20);
    end
    bus.req = '0;

    // Early release of producer 2 hands the pointer to 3 ahead of 0.
    do_reset();
    model_en = 1'b1;
    rd = 1'b1;
    bus.req_data = 32'hD3C2B1A0;
    bus.req = 4'b1100;
    tick(); chk("er_b1",     32'(s_gnt), 32'b0100);
    tick(); chk("er_b2",     32'(s_gnt), 32'b0100);
    bus.req = 4'b1001;
    tick(); chk("er_bubble", 32'(s_gnt), 32'b0000);
    tick(); chk("er_next",   32'(s_gnt), 32'b1000);
    chk("er_data", 32'(s_data), 32'hD3);

    // Reset mid-burst discards ownership and beat count.
    do_reset();
    model_en = 1'b1;
    rd = 1'b0;
    bus.req_data = 32'hD3C2B1A0;
    bus.req = 4'b0010;
    tick(); chk("mr_b1", 32'(s_gnt), 32'b0010);
    tick(); chk("mr_b2", 32'(s_gnt), 32'b0010);
    reset = 1'b1;
    #1;
    chk("mr_async_gnt",  32'(bus.gnt), 32'h0);
    chk("mr_async_we",   32'(bus.fifo_wr_enable), 32'h0);
    chk("mr_async_data", 32'(bus.fifo_data_in), 32'h0);
    tick();
    chk("mr_held_gnt", 32'(s_gnt), 32'h0);
    fq.delete();
    bus.fifo_full = 1'b0;
    reset = 1'b0;
    bus.req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("mr_post%0d", c), 32'(s_gnt), 32'b0010);
    end
    tick();
    chk("mr_rotate", 32'(s_gnt), 32'b1000);
    chk("mr_fifo_size", 32'(fq.size()), 32'd5);
    bus.req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
